eq_sweep_checker: RTL and testbench
===================================

# eq_sweep_checker

Self-checking stimulus generator for the equality-comparator path. It drives every ordered pair of WIDTH-bit operands onto a comparator's `a`/`b` inputs and samples the comparator's `ledpin` result. It checks each result against its own expected `a == b`, counts mismatches and records the first failing pair. It sits on the opposite side of the comparator interface, as the board-level or bench-level driver and reader of that interface.

## Interface
- `WIDTH`, default 2: operand width; drives the `a`/`b` width of the comparator under test.
- `SETTLE`, default 1 (legal ≥1): cycles each pair is driven before `ledpin` is sampled.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level-sampled; begins a full sweep when in IDLE or DONE.
- `ledpin`  in  1  comparator result (1 = operands equal).
- `a`  out  WIDTH  operand A driven to comparator.
- `b`  out  WIDTH  operand B driven to comparator.
- `busy`  out  1  high while sweeping (DRIVE or CHECK).
- `done`  out  1  high in DONE; held until the next start or reset.
- `pass`  out  1  valid when `done`=1: 1 if `err_count` = 0.
- `err_count`  out  2*WIDTH+1  number of mismatching pairs in the last/current sweep.
- `fail_valid`  out  1  a first failure has been captured.
- `fail_a`, `fail_b`  out  WIDTH each  operands of the first mismatching pair.

## Operation
- States: IDLE, DRIVE, CHECK, DONE. All outputs are registered.
- Pair index `idx` is 2*WIDTH bits. `a` = `idx[2W-1:W]`; `b` = `idx[W-1:0]`. The sweep runs `idx` from 0 up to all-ones, in order.
- IDLE:
  - Outputs `a`=`b`=0, `busy`=0, `done`=0.
  - On `start`=1, the next state is DRIVE with `idx`=0.
  - Also on `start`=1: clear `err_count`, `fail_valid`, `fail_a`, `fail_b`.
- DRIVE:
  - Hold `a`/`b` for exactly SETTLE cycles, counted by a settle counter.
  - Then go to CHECK.
- CHECK (one cycle):
  - Compute `expected` = (`a` == `b`).
  - If `ledpin` != `expected`:
    - increment `err_count`;
    - if `fail_valid`=0, capture `fail_a`=`a`, `fail_b`=`b` and set `fail_valid`.
  - If `idx` = all-ones, go to DONE.
  - Otherwise `idx`+1 and go to DRIVE.
- DONE:
  - `done`=1; `pass` = (`err_count` == 0).
  - `a`/`b` hold the last pair.
  - On `start`=1, restart exactly as from IDLE, clearing all results.
- `start` is ignored while `busy`=1.
- `err_count` cannot overflow: its maximum is 2^(2W), which fits in 2W+1 bits. No saturation logic.
- `ledpin` is treated as combinationally derived from `a`/`b`. SETTLE covers any external registering or synchronizer delay.
- Reset values, any state:
  - state IDLE, `idx`=0, `a`=`b`=0;
  - `busy`=0, `done`=0, `pass`=0;
  - `err_count`=0, `fail_valid`=0, `fail_a`=`fail_b`=0.
- Reset mid-sweep aborts immediately. No partial results are retained.

## Timing
- Cycle numbering:
  - `start` is sampled high at edge k.
  - DRIVE begins in cycle k+1 with `a`=`b`=0 and `busy`=1.
  - Pair i is driven in cycles k+1+i*(SETTLE+1) through k+(i+1)*(SETTLE+1).
  - The last cycle of each pair is CHECK, where `ledpin` is sampled.
  - `a`/`b` change in the cycle after CHECK.
- Latency from start to done: the last CHECK is at cycle k+2^(2W)*(SETTLE+1). `done`=1 and `busy`=0 from the following cycle.
  - WIDTH=2, SETTLE=1: `done` from k+33.
  - WIDTH=2, SETTLE=3: `done` from k+65.
- `err_count`, `fail_*` and `fail_valid` update one cycle after the failing CHECK.
- `pass` is valid in the same cycle `done` rises.
- `start` held high continuously in DONE: a new sweep begins one cycle after DONE is entered. `done` is high for exactly one cycle.

## Test plan
- Correct comparator model (`ledpin` = (`a`==`b`)), WIDTH=2, SETTLE=1, start at k:
  - `done` rises at k+33 with `pass`=1, `err_count`=0, `fail_valid`=0;
  - all 16 pairs appear in order 00/00, 00/01, …, 11/11.
- `ledpin` stuck at 1:
  - `err_count`=12, `pass`=0;
  - `fail_a`=0, `fail_b`=1.
- `ledpin` stuck at 0:
  - `err_count`=4;
  - `fail_a`=0, `fail_b`=0.
- Inverted comparator: `err_count`=16 with no wrap; `fail_a`=`fail_b`=0.
- `start` pulsed mid-sweep:
  - no restart, and `done` still at k+33.
  - `reset` asserted at cycle k+10: the next cycle shows `a`=`b`=0, `busy`=0 and `err_count`=0.
  - A later start runs a full clean sweep.
- SETTLE=3 with a comparator model delayed 2 cycles:
  - `pass`=1 and `done` at k+65.
  - Repeating with SETTLE=1 gives `err_count` > 0.

Source files
------------

// File: rtl/eq_sweep_checker.sv
// Purpose: sweeps every ordered (a,b) operand pair into an equality comparator and checks ledpin.
// Latency: each pair takes SETTLE+1 cycles; done rises 2^(2*WIDTH)*(SETTLE+1)+1 cycles after start.
// Backpressure: none; start is level-sampled only in IDLE/DONE and ignored while busy.
module eq_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ledpin,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    // Pair index holds {a, b}; one extra error-count bit covers the all-pairs-fail case.
    localparam int IW = 2 * WIDTH;
    localparam int EW = IW + 1;
    // Settle counter runs 0 .. SETTLE-1 inside DRIVE.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [IW-1:0] IDX_LAST    = {IW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [EW-1:0]   err_q, err_d;
    logic            fv_q, fv_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;

    // Comparison of the pair currently on the bus against the sampled comparator result.
    logic            expected;
    logic            mismatch;
    logic [EW-1:0]   err_upd;

    assign expected = (idx_q[IW-1:WIDTH] == idx_q[WIDTH-1:0]);
    assign mismatch = (ledpin != expected);
    assign err_upd  = err_q + {{IW{1'b0}}, mismatch};

    // State and result registers; reset aborts any sweep and discards partial results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
        end
    end

    // Next-state logic: every status output is computed here and registered, so
    // busy/done/pass change on the same edge as the state they describe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fa_d    = fa_q;
        fb_d    = fb_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new sweep always starts from pair 0 with all results cleared.
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fa_d    = '0;
                    fb_d    = '0;
                end
            end

            ST_DRIVE: begin
                // Hold the pair for SETTLE cycles so the comparator path can settle.
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            ST_CHECK: begin
                err_d = err_upd;
                // Only the first failing pair is kept; later failures just count.
                if (mismatch && !fv_q) begin
                    fv_d = 1'b1;
                    fa_d = idx_q[IW-1:WIDTH];
                    fb_d = idx_q[WIDTH-1:0];
                end
                if (idx_q == IDX_LAST) begin
                    // idx stays at the last pair so a/b keep showing it in DONE.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_upd == '0);
                end else begin
                    state_d = ST_DRIVE;
                    idx_d   = idx_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The operand bus is a direct view of the registered pair index.
    assign a          = idx_q[IW-1:WIDTH];
    assign b          = idx_q[WIDTH-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;

endmodule

// File: tb/tb_eq_sweep_checker.sv
// Purpose: self-checking bench for eq_sweep_checker with several comparator fault models.
// Latency: expects done 2^(2W)*(SETTLE+1)+1 cycles after start.
// Backpressure: none; the bench drives start/reset and emulates the comparator.
module tb_eq_sweep_checker;

    localparam int W    = 2;
    localparam int NP   = 1 << (2 * W);
    localparam int MASK = (1 << W) - 1;

    // Comparator fault models
    localparam int M_OK    = 0;
    localparam int M_ST1   = 1;
    localparam int M_ST0   = 2;
    localparam int M_INV   = 3;
    localparam int M_DLY2  = 4;
    localparam int M_RAND  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start1 = 1'b0, start3 = 1'b0;
    logic led1, led3;
    logic [W-1:0] a1, b1, a3, b3, fa1, fb1, fa3, fb3;
    logic busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
    logic [2*W:0] err1, err3;

    int   mode1 = M_OK, mode3 = M_OK;
    logic flip_tab [NP];
    logic p1a = 1'b1, p1b = 1'b1, p3a = 1'b1, p3b = 1'b1;

    int checks = 0;
    int errors = 0;
    int sel = 0;

    eq_sweep_checker #(.WIDTH(W), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .start(start1), .ledpin(led1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
    );

    eq_sweep_checker #(.WIDTH(W), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .ledpin(led3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3)
    );

    function automatic logic comp_out(input int mode, input logic eq, input logic dly, input logic flip);
        case (mode)
            M_OK:    return eq;
            M_ST1:   return 1'b1;
            M_ST0:   return 1'b0;
            M_INV:   return !eq;
            M_DLY2:  return dly;
            default: return eq ^ flip;
        endcase
    endfunction

    assign led1 = comp_out(mode1, a1 == b1, p1b, flip_tab[{a1, b1}]);
    assign led3 = comp_out(mode3, a3 == b3, p3b, flip_tab[{a3, b3}]);

    // Two-cycle delayed comparator result
    always @(posedge clk) begin
        p1a <= (a1 == b1);
        p1b <= p1a;
        p3a <= (a3 == b3);
        p3b <= p3a;
    end

    logic g_busy, g_done, g_pass, g_fv;
    logic [W-1:0] g_a, g_b, g_fa, g_fb;
    logic [2*W:0] g_err;
    always_comb begin
        if (sel == 1) begin
            g_busy = busy3; g_done = done3; g_pass = pass3; g_fv = fv3;
            g_a = a3; g_b = b3; g_fa = fa3; g_fb = fb3; g_err = err3;
        end else begin
            g_busy = busy1; g_done = done1; g_pass = pass1; g_fv = fv1;
            g_a = a1; g_b = b1; g_fa = fa1; g_fb = fb1; g_err = err1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 1) start3 = v;
        else          start1 = v;
    endtask

    // Reference: walk all pairs in sweep order and decide what the comparator shows
    // at each check point, given the fault model and how long each pair is held.
    task automatic model(input int mode, input int s, output int e, output int fa,
                         output int fb, output int fv);
        int ai, bi, pi;
        logic eq, peq, obs;
        e = 0; fa = 0; fb = 0; fv = 0;
        for (int i = 0; i < NP; i++) begin
            ai  = i >> W;
            bi  = i & MASK;
            eq  = (ai == bi);
            pi  = i - 1;
            // before pair 0 the bus idles on an equal pair (0/0 or last/last)
            peq = (i == 0) ? 1'b1 : (((pi >> W) == (pi & MASK)) ? 1'b1 : 1'b0);
            case (mode)
                M_OK:    obs = eq;
                M_ST1:   obs = 1'b1;
                M_ST0:   obs = 1'b0;
                M_INV:   obs = !eq;
                // a 2-cycle delay still lands inside the same pair only if it was held >= 2 cycles
                M_DLY2:  obs = (s >= 2) ? eq : peq;
                default: obs = eq ^ flip_tab[i];
            endcase
            if (obs != eq) begin
                e++;
                if (fv == 0) begin
                    fv = 1; fa = ai; fb = bi;
                end
            end
        end
    endtask

    // Start a sweep, follow it cycle by cycle, and return the cycle (relative to the
    // start edge) at which done was first seen, or -1 on timeout.
    task automatic run_sweep(input int which, input int s, input bit mid_start,
                             input bit hold, output int done_cyc);
        bit order_ok;
        int i;
        sel = which;
        set_start(1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(1'b0);
        order_ok = 1'b1;
        done_cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            if (mid_start && c == 10) set_start(1'b1);
            if (mid_start && c == 11) set_start(1'b0);
            if (g_done === 1'b1) begin
                done_cyc = c;
                break;
            end
            i = (c - 1) / (s + 1);
            if (g_busy !== 1'b1) order_ok = 1'b0;
            if (i >= NP) order_ok = 1'b0;
            else if (g_a !== W'(i >> W) || g_b !== W'(i & MASK)) order_ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("pair_order", {31'd0, order_ok}, 32'd1);
        chk("done_cycle", done_cyc, NP * (s + 1) + 1);
        chk("busy_at_done", {31'd0, g_busy}, 32'd0);
    endtask

    typedef struct {
        int   mode;
        int   exp_err;
        logic exp_pass;
        int   exp_fa;
        int   exp_fb;
        logic exp_fv;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int dc, me, mfa, mfb, mfv;

        tbl[0] = '{M_OK,  0,  1'b1, 0, 0, 1'b0};
        tbl[1] = '{M_ST1, 12, 1'b0, 0, 1, 1'b1};
        tbl[2] = '{M_ST0, 4,  1'b0, 0, 0, 1'b1};
        tbl[3] = '{M_INV, 16, 1'b0, 0, 0, 1'b1};
        for (int i = 0; i < NP; i++) flip_tab[i] = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", a1, 0);
        chk("rst_b", b1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err", err1, 0);
        chk("rst_fv", fv1, 0);
        chk("rst_fab", {fa1, fb1}, 0);
        chk("rst3_busy_done", {busy3, done3}, 0);
        reset = 1'b0;

        // Table of fault models on the SETTLE=1 instance
        for (int v = 0; v < 4; v++) begin
            mode1 = tbl[v].mode;
            run_sweep(0, 1, 1'b0, 1'b0, dc);
            chk($sformatf("t%0d_err", v), err1, tbl[v].exp_err);
            chk($sformatf("t%0d_pass", v), pass1, tbl[v].exp_pass);
            chk($sformatf("t%0d_fv", v), fv1, tbl[v].exp_fv);
            chk($sformatf("t%0d_fa", v), fa1, tbl[v].exp_fa);
            chk($sformatf("t%0d_fb", v), fb1, tbl[v].exp_fb);
            model(tbl[v].mode, 1, me, mfa, mfb, mfv);
            chk($sformatf("t%0d_err_model", v), err1, me);
            chk($sformatf("t%0d_done_hold_ab", v), {a1, b1}, NP - 1);
        end

        // start pulsed mid-sweep is ignored
        mode1 = M_OK;
        run_sweep(0, 1, 1'b1, 1'b0, dc);
        chk("mid_start_pass", pass1, 1);

        // start held high: done lasts one cycle then a new sweep begins
        run_sweep(0, 1, 1'b0, 1'b1, dc);
        chk("hold_pass", pass1, 1);
        @(posedge clk); #1;
        chk("hold_done_low", done1, 0);
        chk("hold_busy", busy1, 1);
        chk("hold_ab_zero", {a1, b1}, 0);
        start1 = 1'b0;

        // reset at k+10 during a failing sweep
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mode1 = M_ST1;
        sel = 0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        // pairs 0..3 checked by cycle 9; three of them are unequal
        chk("pre_reset_err", err1, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post_reset_ab", {a1, b1}, 0);
        chk("post_reset_busy", busy1, 0);
        chk("post_reset_err", err1, 0);
        chk("post_reset_fv", fv1, 0);
        mode1 = M_OK;
        run_sweep(0, 1, 1'b0, 1'b0, dc);
        chk("clean_after_reset_err", err1, 0);
        chk("clean_after_reset_pass", pass1, 1);

        // delayed comparator: enough settle time on SETTLE=3, not on SETTLE=1
        mode3 = M_DLY2;
        run_sweep(1, 3, 1'b0, 1'b0, dc);
        chk("dly_s3_pass", pass3, 1);
        chk("dly_s3_err", err3, 0);
        mode1 = M_DLY2;
        run_sweep(0, 1, 1'b0, 1'b0, dc);
        chk("dly_s1_err_nonzero", {31'd0, (err1 != 0)}, 1);
        model(M_DLY2, 1, me, mfa, mfb, mfv);
        chk("dly_s1_err_model", err1, me);
        chk("dly_s1_fab_model", {fa1, fb1}, (mfa << W) | mfb);
        chk("dly_s1_pass", pass1, 0);

        // random per-pair fault patterns
        mode1 = M_RAND;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NP; i++) flip_tab[i] = 1'($urandom_range(0, 1));
            model(M_RAND, 1, me, mfa, mfb, mfv);
            run_sweep(0, 1, 1'b0, 1'b0, dc);
            chk($sformatf("rnd%0d_err", r), err1, me);
            chk($sformatf("rnd%0d_pass", r), pass1, (me == 0) ? 1 : 0);
            chk($sformatf("rnd%0d_fv", r), fv1, mfv);
            chk($sformatf("rnd%0d_fab", r), {fa1, fb1}, (mfa << W) | mfb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
